sum_frame_acc: RTL and testbench



---
 rtl/sum_frame_acc.sv | 152 +++++++++++++++
 tb/tb_sum_frame_acc.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sum_frame_acc.sv
// sum_frame_acc: accumulates FRAME_LEN unsigned sum beats into one wide
// frame total and emits {total, beat count, overflow} as one output beat.
// A flush pulse closes a partial frame early.
//
// Optional feature macro: SUM_FRAME_ACC_SAT_EN
//   defined   -> the accumulator saturates at 2^ACC_W-1 on overflow
//   undefined -> the accumulator wraps modulo 2^ACC_W
// In both builds out_ovf reports that a carry out of ACC_W occurred.
module sum_frame_acc #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 16,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_ovf,
  input  logic              out_ready
);

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic               out_ovf_q, out_ovf_d;

  logic               accept;
  logic               frame_close;
  logic               out_take;
  logic [ACC_W:0]     add_res;

  // Add one beat to the running total. Bit ACC_W of the result flags a carry
  // out of the accumulator; the low ACC_W bits are the new accumulator value,
  // either wrapped or clamped at full scale depending on the build.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0]  a,
                                             input logic [DATA_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W + 1)'(b);
`ifdef SUM_FRAME_ACC_SAT_EN
    if (s[ACC_W]) begin
      s = {1'b1, {ACC_W{1'b1}}};
    end
`endif
    return s;
  endfunction

  assign accept   = in_valid && in_ready;
  assign out_take = out_valid_q && out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: close a frame into HOLD, leave HOLD on output handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (frame_close) state_d = HOLD;
      HOLD:    if (out_take)    state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // FSM output: input side is open only while accumulating and out of reset.
  always_comb begin
    in_ready = !reset && (state_q == ACCUM);
  end

  // Accumulator update and frame-close decision, including a beat that
  // arrives in the same cycle as the closing condition.
  always_comb begin
    add_res     = acc_add(acc_q, in_data);
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    if (accept) begin
      acc_d = add_res[ACC_W-1:0];
      cnt_d = cnt_q + CNT_W'(1);
      ovf_d = ovf_q | add_res[ACC_W];
    end

    frame_close = (state_q == ACCUM) &&
                  ((accept && (cnt_d == FRAME_CNT)) ||
                   (flush && ((cnt_q != '0) || accept)));

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    out_ovf_d   = out_ovf_q;

    if (frame_close) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_d;
      out_cnt_d   = cnt_d;
      out_ovf_d   = ovf_d;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
    end else if (out_take) begin
      out_valid_d = 1'b0;
    end
  end

  // Frame accumulator and registered output beat; reset discards a partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_cnt   = out_cnt_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_sum_frame_acc.sv
// Bench for sum_frame_acc: two instances (ACC_W=16 default and ACC_W=9 for
// overflow) share one stimulus stream. A frame-level reference model pushes
// expected output beats into a queue; a monitor pops and compares them.
module tb_sum_frame_acc;

  localparam int FL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        flush;
  logic        out_ready;

  logic        in_ready16, out_valid16, out_ovf16;
  logic [15:0] out_data16;
  logic [2:0]  out_cnt16;
  logic        in_ready9, out_valid9, out_ovf9;
  logic [8:0]  out_data9;
  logic [2:0]  out_cnt9;

  sum_frame_acc #(.DATA_W(8), .ACC_W(16), .FRAME_LEN(FL)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready16), .flush(flush), .out_valid(out_valid16),
    .out_data(out_data16), .out_cnt(out_cnt16), .out_ovf(out_ovf16),
    .out_ready(out_ready)
  );

  sum_frame_acc #(.DATA_W(8), .ACC_W(9), .FRAME_LEN(FL)) dut9 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready9), .flush(flush), .out_valid(out_valid9),
    .out_data(out_data9), .out_cnt(out_cnt9), .out_ovf(out_ovf9),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d16;
    int ovf16;
    int d9;
    int ovf9;
    int cnt;
  } exp_t;

  exp_t expq[$];
  int   beats[$];
  bit   hold     = 1'b0;
  bit   rst_seen = 1'b0;
  bit   started  = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  // Expected frame total for an accumulator of width w.
  function automatic int exp_val(input int total, input int w);
    int lim;
    lim = 1 << w;
`ifdef SUM_FRAME_ACC_SAT_EN
    return (total >= lim) ? lim - 1 : total;
`else
    return total % lim;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: frame-level behaviour evaluated at each active edge.
  always @(posedge clk) begin
    if (reset) begin
      beats.delete();
      expq.delete();
      hold     = 1'b0;
      rst_seen = 1'b1;
    end else begin
      rst_seen = 1'b0;
      if (hold) begin
        if (out_ready) hold = 1'b0;
      end else begin
        if (in_valid) beats.push_back(int'(in_data));
        if ((in_valid && beats.size() == FL) || (flush && beats.size() > 0)) begin
          exp_t e;
          int   total;
          total = 0;
          foreach (beats[k]) total += beats[k];
          e.d16   = exp_val(total, 16);
          e.ovf16 = (total >= (1 << 16)) ? 1 : 0;
          e.d9    = exp_val(total, 9);
          e.ovf9  = (total >= (1 << 9)) ? 1 : 0;
          e.cnt   = beats.size();
          expq.push_back(e);
          beats.delete();
          hold = 1'b1;
        end
      end
    end
  end

  // Monitor: compare handshake signals each cycle and output beats against
  // the head of the expectation queue; pop on the output handshake.
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready16", int'(in_ready16), int'(!reset && !hold));
      chk("in_ready9",  int'(in_ready9),  int'(!reset && !hold));
      if (rst_seen) begin
        chk("rst_out_valid", int'(out_valid16) + int'(out_valid9), 0);
        chk("rst_out_data",  int'(out_data16) + int'(out_data9), 0);
        chk("rst_out_cnt",   int'(out_cnt16) + int'(out_cnt9), 0);
        chk("rst_out_ovf",   int'(out_ovf16) + int'(out_ovf9), 0);
      end else begin
        chk("out_valid16", int'(out_valid16), int'(hold));
        chk("out_valid9",  int'(out_valid9),  int'(hold));
        if (out_valid16 || out_valid9) begin
          if (expq.size() == 0) begin
            chk("unexpected_out", 1, 0);
          end else begin
            chk("out_data16", int'(out_data16), expq[0].d16);
            chk("out_ovf16",  int'(out_ovf16),  expq[0].ovf16);
            chk("out_cnt16",  int'(out_cnt16),  expq[0].cnt);
            chk("out_data9",  int'(out_data9),  expq[0].d9);
            chk("out_ovf9",   int'(out_ovf9),   expq[0].ovf9);
            chk("out_cnt9",   int'(out_cnt9),   expq[0].cnt);
            if (out_ready) void'(expq.pop_front());
          end
        end
      end
    end
  end

  task automatic cyc(input bit v, input int d, input bit f, input bit r);
    in_valid  = v;
    in_data   = 8'(d);
    flush     = f;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    started = 1'b1;
    cyc(1'b0, 0, 1'b0, 1'b1);
    reset = 1'b0;

    // Full frame 10+20+30+40
    cyc(1, 10, 0, 1); cyc(1, 20, 0, 1); cyc(1, 30, 0, 1); cyc(1, 40, 0, 1);
    idle(3);

    // Overflow: 4 x 255 exceeds the 9-bit accumulator
    for (int i = 0; i < 4; i++) cyc(1, 255, 0, 1);
    idle(2);

    // Backpressure: output held for 3 cycles, then taken
    cyc(1, 1, 0, 0); cyc(1, 2, 0, 0); cyc(1, 3, 0, 0); cyc(1, 4, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b0, 1'b0);
    idle(2);

    // Flush alone after two beats
    cyc(1, 5, 0, 1); cyc(1, 7, 0, 1); cyc(0, 0, 1, 1);
    idle(2);

    // Flush together with the fourth beat
    cyc(1, 1, 0, 1); cyc(1, 2, 0, 1); cyc(1, 3, 0, 1); cyc(1, 9, 1, 1);
    idle(2);

    // Flush with an empty frame produces nothing
    cyc(0, 0, 1, 1);
    idle(2);

    // Reset mid-frame discards 50 and 60
    cyc(1, 50, 0, 1); cyc(1, 60, 0, 1);
    reset = 1'b1;
    cyc(0, 0, 0, 1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1);
    idle(2);

    // Back-to-back frames with in_valid and out_ready held high
    for (int i = 0; i < 3 * (FL + 1); i++) cyc(1, $urandom_range(0, 255), 0, 1);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 255),
          $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
    end
    reset = 1'b0;

    // Close any partial frame and let the result drain
    idle(2);
    cyc(0, 0, 1, 1);
    idle(4);
    chk("drain_empty", expq.size(), 0);

    started = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
